// File: rtl/dii_package.sv
// Debug-interconnect flit type shared by the ring blocks.
package dii_package;

    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;

endpackage

// File: rtl/dii_buffer.sv
// Ready/valid flit FIFO of arbitrary depth (pointers wrap explicitly, so the
// depth need not be a power of two). Storage is not reset.
module dii_buffer
    import dii_package::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  dii_flit in_flit,
    output logic    in_ready,
    output dii_flit out_flit,
    input  logic    out_ready
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [16:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    // Handshake and head-of-queue view; ready depends only on registered occupancy.
    always_comb begin
        in_ready       = (count != CNT_FULL);
        out_flit.valid = (count != '0);
        out_flit.last  = mem[rd_ptr][16];
        out_flit.data  = mem[rd_ptr][15:0];
        push           = in_flit.valid & in_ready;
        pop            = out_flit.valid & out_ready;
    end

    // Flit storage write; contents survive reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_flit.last, in_flit.data};
        end
    end

    // Pointer and occupancy bookkeeping with wrap at DEPTH-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/debug_ring_turnaround.sv
// Debug ring turnaround: sub-ring 0 tail loops to sub-ring 1 head through a
// FIFO; sub-ring 1 tail is a sink whose packets were refused by every router,
// so they are dropped and accounted.
//
// Drop FSM states
//   state | meaning
//   IDLE  | next sub-ring 1 flit is the first of a packet
//   DROP  | inside a multi-flit packet, discarding until last
module debug_ring_turnaround
    import dii_package::*;
#(
    parameter int BUFFER_SIZE = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  dii_flit [1:0] tail_in,
    output logic    [1:0] tail_in_ready,
    output dii_flit [1:0] head_out,
    input  logic    [1:0] head_out_ready,
    output logic   [15:0] drop_count,
    output logic   [15:0] drop_dest,
    output logic          drop_event
);

    typedef enum logic {
        IDLE = 1'b0,
        DROP = 1'b1
    } drop_state_t;

    drop_state_t drop_state;
    dii_flit     fifo_out;
    logic        fifo_in_ready;
    logic        unused_head_ready0;

    dii_buffer #(
        .DEPTH (BUFFER_SIZE)
    ) u_buffer (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (tail_in[0]),
        .in_ready  (fifo_in_ready),
        .out_flit  (fifo_out),
        .out_ready (head_out_ready[1])
    );

    // Sub-ring 0 head is never used; sub-ring 1 tail is always accepted.
    always_comb begin
        head_out           = {fifo_out, dii_flit'('0)};
        tail_in_ready      = {1'b1, fifo_in_ready};
        unused_head_ready0 = head_out_ready[0];
    end

    // Drop FSM: first flit of each packet is counted and its destination latched.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_state <= IDLE;
            drop_count <= '0;
            drop_dest  <= '0;
            drop_event <= 1'b0;
        end else begin
            drop_event <= 1'b0;
            if (tail_in[1].valid) begin
                case (drop_state)
                    IDLE: begin
                        drop_dest  <= tail_in[1].data;
                        drop_event <= 1'b1;
                        if (drop_count != 16'hFFFF) begin
                            drop_count <= drop_count + 16'd1;
                        end
                        if (!tail_in[1].last) begin
                            drop_state <= DROP;
                        end
                    end
                    DROP: begin
                        if (tail_in[1].last) begin
                            drop_state <= IDLE;
                        end
                    end
                    default: drop_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/debug_ring_turnaround.md
DEBUG_RING_TURNAROUND -- requirements
Module: debug_ring_turnaround

Interface
REQ-001 SHALL have parameter BUFFER_SIZE, default 4, meaning the depth in flits of the turnaround FIFO; legal range is 2..64.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port tail_in, input, dii_flit [1:0]: tails of sub-rings 0 and 1, connected to the ring segment's ext_out.
REQ-005 SHALL have port tail_in_ready, output, [1:0]: ready for tail_in.
REQ-006 SHALL have port head_out, output, dii_flit [1:0]: heads of sub-rings 0 and 1, connected to the ring segment's ext_in.
REQ-007 SHALL have port head_out_ready, input, [1:0]: ready for head_out.
REQ-008 SHALL have port drop_count, output, 16 bits: number of packets discarded at the tail of sub-ring 1.
REQ-009 SHALL have port drop_dest, output, 16 bits: destination word (first-flit data) of the most recently dropped packet.
REQ-010 SHALL have port drop_event, output, 1 bit: one-cycle pulse per dropped packet.

Function
REQ-011 SHALL treat a flit as transferred when valid and ready are both high in the same cycle; in this block valid never depends combinationally on ready.
REQ-012 SHALL forward sub-ring 0 tail (tail_in[0]) to sub-ring 1 head (head_out[1]) through a BUFFER_SIZE-deep FIFO, preserving data, last and order.
REQ-013 SHALL drive tail_in_ready[0] = FIFO not full, from registered occupancy only.
REQ-014 SHALL drive head_out[1].valid = FIFO not empty, with data/last taken from the FIFO head; minimum latency from tail_in[0] to head_out[1] is 1 cycle.
REQ-015 SHALL allow a simultaneous push and pop when the FIFO is full: the pop frees the slot, the push is still rejected that cycle because ready was low, and occupancy decrements by 1.
REQ-016 SHALL, on a simultaneous push and pop when 0 < occupancy < BUFFER_SIZE, leave occupancy unchanged.
REQ-017 SHALL wrap the read and write pointers from BUFFER_SIZE-1 to 0, including for non-power-of-two BUFFER_SIZE.
REQ-018 SHALL drive head_out[0].valid constantly 0; head_out[0].data and .last are 0; head_out_ready[0] is ignored.
REQ-019 SHALL drive tail_in_ready[1] constantly 1 and discard every sub-ring 1 tail flit, because these packets have passed every router without being accepted.
REQ-020 SHALL run a drop FSM with states IDLE and DROP: IDLE moves to DROP on an accepted tail_in[1] flit with last=0; DROP returns to IDLE on an accepted flit with last=1; all other cases hold state.
REQ-021 SHALL, on an accepted tail_in[1] flit while in IDLE (first flit, including single-flit packets with last=1 that keep the FSM in IDLE), register drop_dest <= flit data, increment drop_count, and assert drop_event on the next cycle for exactly one cycle.
REQ-022 SHALL saturate drop_count at 16'hFFFF; drop_event still pulses at saturation.
REQ-023 SHALL register drop_count, drop_dest and drop_event directly from flops.

Reset
REQ-024 SHALL, with rst high at a clock edge, clear FIFO pointers and occupancy, force the drop FSM to IDLE, and clear drop_count, drop_dest and drop_event to 0.
REQ-025 SHALL hold head_out[1].valid = 0 and tail_in_ready[0] = 1 from the first cycle after reset.
REQ-026 SHALL discard a packet that is partially buffered or mid-drop when reset asserts mid-operation; there is no recovery of partial packets.
REQ-027 SHALL NOT reset FIFO storage contents.

Structure
REQ-028 SHALL take dii_flit (valid, last, data[15:0]) from dii_package; no new package types are needed.
REQ-029 SHALL implement the FIFO as one sub-module, dii_buffer, parameterised by depth, with a ready/valid interface on both sides.
REQ-030 SHALL implement the drop FSM and counters inline in debug_ring_turnaround.

Verification
REQ-031 SHALL cover the pass-through scenario: 3-flit packet (0x0005, 0x1234, 0xABCD last) on tail_in[0] with head_out_ready[1]=1 -> the same three flits appear on head_out[1] in order, first one cycle after acceptance, and last is set only on 0xABCD.
REQ-032 SHALL cover the backpressure scenario: BUFFER_SIZE=4, head_out_ready[1]=0, 6 flits offered -> tail_in_ready[0] drops after 4 accepts; after ready is released, all 6 flits emerge in order with no duplicates.
REQ-033 SHALL cover the full-FIFO push/pop scenario: push and pop in the same cycle with the FIFO full -> push rejected, occupancy 3 afterward.
REQ-034 SHALL cover the drop-accounting scenario: two packets on tail_in[1] (2-flit dest 0x0007, then 1-flit dest 0x0009) -> drop_count=2, drop_dest=0x0009, two one-cycle drop_event pulses.
REQ-035 SHALL cover the saturation scenario: preload drop_count near 0xFFFE and drop 3 packets -> drop_count holds at 0xFFFF.
REQ-036 SHALL cover the mid-packet reset scenario: rst asserted after the first flit of a 3-flit packet on both tails -> all outputs at reset values; a following packet forwards and counts correctly.
